alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts, optional shift-add multiply.
// Define ALU_SEQ_MUL_EN to build the multiplier (Op 1000); otherwise Op 1000 is an unused code.
module alu_seq #(
    parameter int WIDTH = 24,
    parameter int SHW   = 5
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done,
    output logic             Zero,
    output logic             CarryOut,
    output logic             Overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
`endif

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        SHIFT,
`ifdef ALU_SEQ_MUL_EN
        MUL,
`endif
        DONE
    } state_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t           state, state_nx;
    req_t             req;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    cnt;
    logic [31:0]      shamt;
    logic [CW-1:0]    cnt_ld;

    logic             is_sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] exec_res;
    logic             exec_c, exec_v;

    // Shift counts at or beyond WIDTH saturate: WIDTH steps already clear the register.
    assign shamt  = 32'(B[SHW-1:0]);
    assign cnt_ld = (shamt >= WIDTH) ? CW'(WIDTH) : CW'(shamt);

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Op == OP_SLL || Op == OP_SRL) state_nx = SHIFT;
`ifdef ALU_SEQ_MUL_EN
                    else if (Op == OP_MUL)            state_nx = MUL;
`endif
                    else                              state_nx = EXEC;
                end
            end
            EXEC:    state_nx = DONE;
            SHIFT:   if (cnt == '0) state_nx = DONE;
`ifdef ALU_SEQ_MUL_EN
            MUL:     if (cnt == '0) state_nx = DONE;
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shared add/sub datapath; SLT reuses the subtract and corrects the sign for overflow.
    assign is_sub = (req.op == OP_SUB) || (req.op == OP_SLT);
    assign bx     = is_sub ? ~req.b : req.b;
    assign sum    = {1'b0, req.a} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
    assign ovf    = (req.a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != req.a[WIDTH-1]);

    always_comb begin
        exec_res = '0;
        exec_c   = 1'b0;
        exec_v   = 1'b0;
        case (req.op)
            OP_AND: exec_res = req.a & req.b;
            OP_OR:  exec_res = req.a | req.b;
            OP_XOR: exec_res = req.a ^ req.b;
            OP_ADD, OP_SUB: begin
                exec_res = sum[WIDTH-1:0];
                exec_c   = sum[WIDTH];
                exec_v   = ovf;
            end
            OP_SLT: exec_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // {hi, work} is the product register; work starts as the multiplier and shifts out LSB-first.
    logic [WIDTH-1:0] hi;
    logic [WIDTH:0]   msum;
    assign msum = {1'b0, hi} + {1'b0, (work[0] ? req.a : {WIDTH{1'b0}})};
`endif

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            req      <= '0;
            work     <= '0;
            cnt      <= '0;
            Result   <= '0;
            Zero     <= 1'b0;
            CarryOut <= 1'b0;
            Overflow <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            hi       <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (Start) begin
                    req  <= '{op: Op, a: A, b: B};
                    work <= A;
                    cnt  <= cnt_ld;
`ifdef ALU_SEQ_MUL_EN
                    if (Op == OP_MUL) begin
                        work <= B;
                        hi   <= '0;
                        cnt  <= CW'(WIDTH);
                    end
`endif
                end
                EXEC: begin
                    Result   <= exec_res;
                    Zero     <= (exec_res == '0);
                    CarryOut <= exec_c;
                    Overflow <= exec_v;
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        Result   <= work;
                        Zero     <= (work == '0);
                        CarryOut <= 1'b0;
                        Overflow <= 1'b0;
                    end else begin
                        work <= (req.op == OP_SLL) ? (work << 1) : (work >> 1);
                        cnt  <= cnt - CW'(1);
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    if (cnt == '0) begin
                        Result   <= work;
                        Zero     <= (work == '0);
                        CarryOut <= |hi;
                        Overflow <= 1'b0;
                    end else begin
                        hi   <= msum[WIDTH:1];
                        work <= {msum[0], work[WIDTH-1:1]};
                        cnt  <= cnt - CW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, corner sequences, random ops vs a model.
module tb_alu_seq;
    localparam int W  = 24;
    localparam int SW = 5;

    logic         Clock = 1'b0;
    logic         ResetN, Start;
    logic [3:0]   Op;
    logic [W-1:0] A, B, Result;
    logic         Busy, Done, Zero, CarryOut, Overflow;

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    alu_seq #(.WIDTH(W), .SHW(SW)) dut (
        .Clock(Clock), .ResetN(ResetN), .Start(Start), .Op(Op), .A(A), .B(B),
        .Result(Result), .Busy(Busy), .Done(Done), .Zero(Zero),
        .CarryOut(CarryOut), .Overflow(Overflow)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        bit           z, c, v;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference computed from the op definitions with plain integer arithmetic.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] res, output bit z, output bit c,
                                  output bit v, output int lat);
        longint unsigned mask = (64'd1 << W) - 1;
        longint unsigned full;
        longint sa, sb;
        int n;
        res = '0; c = 0; v = 0; lat = 2;
        n = int'(b[SW-1:0]);
        case (op)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0101: res = a ^ b;
            4'b0010: begin
                full = 64'(a) + 64'(b);
                res  = W'(full);
                c    = ((full >> W) & 1) != 0;
                v    = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            4'b0110: begin
                full = 64'(a) + ((~64'(b)) & mask) + 1;
                res  = W'(full);
                c    = ((full >> W) & 1) != 0;
                v    = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            4'b0111: begin
                sa  = a[W-1] ? longint'(64'(a)) - (longint'(1) << W) : longint'(64'(a));
                sb  = b[W-1] ? longint'(64'(b)) - (longint'(1) << W) : longint'(64'(b));
                res = (sa < sb) ? W'(1) : W'(0);
            end
            4'b0011: begin
                res = (n >= W) ? W'(0) : W'((64'(a) << n) & mask);
                lat = ((n < W) ? n : W) + 2;
            end
            4'b0100: begin
                res = (n >= W) ? W'(0) : W'(64'(a) >> n);
                lat = ((n < W) ? n : W) + 2;
            end
`ifdef ALU_SEQ_MUL_EN
            4'b1000: begin
                full = 64'(a) * 64'(b);
                res  = W'(full);
                c    = (full >> W) != 0;
                lat  = W + 2;
            end
`endif
            default: ;
        endcase
        z = (res == '0);
    endfunction

    // Entered and left just after a rising edge with the DUT idle.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit spam, output logic [W-1:0] res, output bit z, output bit c,
                         output bit v, output int lat);
        bit seen = 0;
        Op = op; A = a; B = b; Start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge Clock); #1;
            if (k == 1) check("busy_after_accept", 64'(Busy), 64'(1));
            if (Done) begin seen = 1; lat = k; break; end
            if (spam) begin
                A = W'($urandom); B = W'($urandom); Op = 4'($urandom); Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
        end
        if (!seen) check("done_timeout", 64'(0), 64'(1));
        res = Result; z = Zero; c = CarryOut; v = Overflow;
        check("busy_at_done", 64'(Busy), 64'(1));
        if (!spam) Start = 1'b0;
        @(posedge Clock); #1;
        Start = 1'b0;
        check("done_one_cycle", 64'(Done), 64'(0));
        check("idle_after_done", 64'(Busy), 64'(0));
        check("result_hold", 64'(Result), 64'(res));
    endtask

    task automatic run_check(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit spam, input logic [W-1:0] eres,
                             input bit ez, input bit ec, input bit ev, input int elat);
        logic [W-1:0] r;
        bit z, c, v;
        int lat;
        do_op(op, a, b, spam, r, z, c, v, lat);
        check($sformatf("%s_result op=%0h a=%0h b=%0h", tag, op, a, b), 64'(r), 64'(eres));
        check($sformatf("%s_zero", tag), 64'(z), 64'(ez));
        check($sformatf("%s_carry", tag), 64'(c), 64'(ec));
        check($sformatf("%s_ovf", tag), 64'(v), 64'(ev));
        check($sformatf("%s_latency", tag), 64'(lat), 64'(elat));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, 64'(Result), 64'(0));
        check({tag, "_busy"}, 64'(Busy), 64'(0));
        check({tag, "_done"}, 64'(Done), 64'(0));
        check({tag, "_zero"}, 64'(Zero), 64'(0));
        check({tag, "_carry"}, 64'(CarryOut), 64'(0));
        check({tag, "_ovf"}, 64'(Overflow), 64'(0));
    endtask

    initial begin
        vec_t vt[$];
        logic [3:0] ops[12] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h5, 4'h7, 4'h3, 4'h4, 4'h8, 4'h9, 4'hF, 4'hA};
        logic [W-1:0] mr, ra, rb;
        bit mz, mc, mv;
        int ml;
        logic [3:0] rop;

        ResetN = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
        #1 ResetN = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge Clock);
        #1 ResetN = 1'b1;
        @(posedge Clock); #1;

        //           op     a          b          res        z  c  v  lat
        vt.push_back('{4'h2, 24'h7FFFFF, 24'h000001, 24'h800000, 0, 0, 1, 2});
        vt.push_back('{4'h6, 24'h123456, 24'h123456, 24'h000000, 1, 1, 0, 2});
        vt.push_back('{4'h2, 24'hFFFFFF, 24'h000001, 24'h000000, 1, 1, 0, 2});
        vt.push_back('{4'h6, 24'h000000, 24'h000001, 24'hFFFFFF, 0, 0, 0, 2});
        vt.push_back('{4'h6, 24'h800000, 24'h000001, 24'h7FFFFF, 0, 1, 1, 2});
        vt.push_back('{4'h7, 24'h800000, 24'h000001, 24'h000001, 0, 0, 0, 2});
        vt.push_back('{4'h7, 24'h000001, 24'h800000, 24'h000000, 1, 0, 0, 2});
        vt.push_back('{4'h3, 24'h000001, 24'd23,     24'h800000, 0, 0, 0, 25});
        vt.push_back('{4'h4, 24'hABCDEF, 24'd0,      24'hABCDEF, 0, 0, 0, 2});
        vt.push_back('{4'h4, 24'hABCDEF, 24'd30,     24'h000000, 1, 0, 0, 26});
        vt.push_back('{4'h0, 24'hF0F0F0, 24'hFF00FF, 24'hF000F0, 0, 0, 0, 2});
        vt.push_back('{4'h5, 24'hF0F0F0, 24'hFF00FF, 24'h0FF00F, 0, 0, 0, 2});
        vt.push_back('{4'hF, 24'h123456, 24'h654321, 24'h000000, 1, 0, 0, 2});
`ifdef ALU_SEQ_MUL_EN
        vt.push_back('{4'h8, 24'h001000, 24'h001000, 24'h000000, 1, 1, 0, 26});
        vt.push_back('{4'h8, 24'h000123, 24'h000456, 24'h04EDC2, 0, 0, 0, 26});
`else
        vt.push_back('{4'h8, 24'h001000, 24'h001000, 24'h000000, 1, 0, 0, 2});
`endif
        foreach (vt[i])
            run_check($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, 1'b0,
                      vt[i].res, vt[i].z, vt[i].c, vt[i].v, vt[i].lat);

        // Reset in the middle of a long shift: outputs clear at once, no Done, then normal operation.
        Op = 4'h3; A = 24'h000001; B = 24'd20; Start = 1'b1;
        @(posedge Clock); #1 Start = 1'b0;
        repeat (4) @(posedge Clock);
        #1 check("midshift_busy", 64'(Busy), 64'(1));
        #2 ResetN = 1'b0;
        #1 check_all_zero("rst_mid");
        @(posedge Clock); #1;
        check("rst_mid_no_done", 64'(Done), 64'(0));
        ResetN = 1'b1;
        @(posedge Clock); #1;
        check("rst_mid_still_idle", 64'(Busy), 64'(0));
        run_check("after_rst", 4'h3, 24'h000001, 24'd4, 1'b0, 24'h000010, 0, 0, 0, 6);

        // Start held high with changing operands throughout a shift and its Done cycle.
        model(4'h4, 24'hC00FFE, 24'd12, mr, mz, mc, mv, ml);
        run_check("spam_srl", 4'h4, 24'hC00FFE, 24'd12, 1'b1, mr, mz, mc, mv, ml);
        model(4'h2, 24'h400000, 24'h400000, mr, mz, mc, mv, ml);
        run_check("spam_add", 4'h2, 24'h400000, 24'h400000, 1'b1, mr, mz, mc, mv, ml);

        for (int i = 0; i < 40; i++) begin
            rop = ops[$urandom_range(0, 11)];
            ra  = W'($urandom);
            rb  = W'($urandom);
            if (i % 5 == 0) rb = ra;
            model(rop, ra, rb, mr, mz, mc, mv, ml);
            run_check($sformatf("rnd%0d", i), rop, ra, rb, (i % 7 == 3), mr, mz, mc, mv, ml);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
